// File: rtl/picmicro_pc_sequencer.sv
// picmicro_pc_sequencer: PC, PCLATH paging, circular return stack and interrupt entry with pipeline flush.
// Define PICMICRO_STACK_STATUS_EN to keep stack occupancy and drive sticky stack_ovf/stack_unf.
module picmicro_pc_sequencer #(
  parameter int PC_WIDTH     = 13,
  parameter int J_WIDTH      = 11,
  parameter int STACK_DEPTH  = 8,
  parameter int RESET_VECTOR = 0,
  parameter int INT_VECTOR   = 4,
  parameter int FLUSH_CYCLES = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           pc_incr_en,
  input  logic                           pc_j_en,
  input  logic                           call_en,
  input  logic                           return_en,
  input  logic                           retfie_en,
  input  logic [J_WIDTH-1:0]             pc_j_addr,
  input  logic                           pcl_wr_en,
  input  logic [7:0]                     pcl_in,
  input  logic                           pclath_wr_en,
  input  logic [PC_WIDTH-9:0]            pclath_in,
  input  logic                           gie,
  input  logic                           int_req,
  input  logic                           boundary_en,
  output logic [PC_WIDTH-1:0]            pc_out,
  output logic [PC_WIDTH-9:0]            pclath_out,
  output logic                           instr_flush,
  output logic                           int_ack,
  output logic                           gie_clr,
  output logic                           gie_set,
  output logic [$clog2(STACK_DEPTH)-1:0] stack_ptr,
  output logic                           stack_ovf,
  output logic                           stack_unf
);
  localparam int PW = $clog2(STACK_DEPTH);
  localparam int FW = $clog2(FLUSH_CYCLES + 1);
  typedef enum logic {RUN, FLUSH} state_t;
  state_t state;
  logic [FW-1:0] fcnt;
  logic [PC_WIDTH-1:0] stack [STACK_DEPTH];
  logic [PC_WIDTH-1:0] jump_target, pc_next;
  logic [PW-1:0] ptr_dec;
  logic run, entry, push, pop;
  assign run = state == RUN;
  assign entry = run & int_req & gie & boundary_en;
  assign pop = run & ~entry & (retfie_en | return_en);
  assign push = entry | (run & call_en & ~retfie_en & ~return_en);
  assign ptr_dec = stack_ptr - 1'b1;
  assign jump_target = {pclath_out[PC_WIDTH-9:J_WIDTH-8], pc_j_addr};
  assign instr_flush = state == FLUSH;
  always_comb
    pc_next = entry                ? PC_WIDTH'(INT_VECTOR) :
              pop                  ? stack[ptr_dec] :
              !run                 ? pc_out :
              (call_en | pc_j_en)  ? jump_target :
              pcl_wr_en            ? {pclath_out, pcl_in} :
              pc_incr_en           ? pc_out + 1'b1 : pc_out;
  always_ff @(posedge clk)
    if (push && rst) stack[stack_ptr] <= pc_out;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      pc_out     <= PC_WIDTH'(RESET_VECTOR);
      pclath_out <= '0;
      stack_ptr  <= '0;
      int_ack    <= 1'b0;
      gie_clr    <= 1'b0;
      gie_set    <= 1'b0;
      state      <= RUN;
      fcnt       <= '0;
    end else begin
      pc_out    <= pc_next;
      stack_ptr <= push ? stack_ptr + 1'b1 : pop ? ptr_dec : stack_ptr;
      int_ack   <= entry;
      gie_clr   <= entry;
      gie_set   <= pop & retfie_en;
      if (pclath_wr_en) pclath_out <= pclath_in;
      if (entry) begin
        state <= FLUSH;
        fcnt  <= FW'(FLUSH_CYCLES - 1);
      end else if (!run) begin
        if (fcnt == '0) state <= RUN;
        else fcnt <= fcnt - 1'b1;
      end
    end
`ifdef PICMICRO_STACK_STATUS_EN
  logic [PW:0] count;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      count     <= '0;
      stack_ovf <= 1'b0;
      stack_unf <= 1'b0;
    end else if (push) begin
      if (count == (PW+1)'(STACK_DEPTH)) stack_ovf <= 1'b1;
      else count <= count + 1'b1;
    end else if (pop) begin
      if (count == '0) stack_unf <= 1'b1;
      else count <= count - 1'b1;
    end
`else
  assign stack_ovf = 1'b0;
  assign stack_unf = 1'b0;
`endif
endmodule

// File: tb/tb_picmicro_pc_sequencer.sv
// tb_picmicro_pc_sequencer: directed checks of paging, stack, interrupt entry and reset.
module tb_picmicro_pc_sequencer;
  logic clk = 0, rst = 0;
  logic pc_incr_en = 0, pc_j_en = 0, call_en = 0, return_en = 0, retfie_en = 0;
  logic [10:0] pc_j_addr = 0;
  logic pcl_wr_en = 0, pclath_wr_en = 0;
  logic [7:0] pcl_in = 0;
  logic [4:0] pclath_in = 0;
  logic gie = 0, int_req = 0, boundary_en = 0;
  logic [12:0] pc_out;
  logic [4:0] pclath_out;
  logic instr_flush, int_ack, gie_clr, gie_set, stack_ovf, stack_unf;
  logic [2:0] stack_ptr;
  int pass = 0, total = 0;
`ifdef PICMICRO_STACK_STATUS_EN
  localparam logic STAT = 1'b1;
`else
  localparam logic STAT = 1'b0;
`endif

  picmicro_pc_sequencer dut (
    .clk(clk), .rst(rst), .pc_incr_en(pc_incr_en), .pc_j_en(pc_j_en), .call_en(call_en),
    .return_en(return_en), .retfie_en(retfie_en), .pc_j_addr(pc_j_addr), .pcl_wr_en(pcl_wr_en),
    .pcl_in(pcl_in), .pclath_wr_en(pclath_wr_en), .pclath_in(pclath_in), .gie(gie),
    .int_req(int_req), .boundary_en(boundary_en), .pc_out(pc_out), .pclath_out(pclath_out),
    .instr_flush(instr_flush), .int_ack(int_ack), .gie_clr(gie_clr), .gie_set(gie_set),
    .stack_ptr(stack_ptr), .stack_ovf(stack_ovf), .stack_unf(stack_unf)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pc(input logic [12:0] v);
    pclath_wr_en = 1; pclath_in = v[12:8];
    tick();
    pclath_wr_en = 0; pcl_wr_en = 1; pcl_in = v[7:0];
    tick();
    pcl_wr_en = 0;
  endtask

  task automatic test_reset();
    rst = 0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (pc_out !== 13'h0) $display("FAIL reset_pc got %h want 0000", pc_out); else pass++;
    total++; if (pclath_out !== 5'h0) $display("FAIL reset_pclath got %h want 00", pclath_out); else pass++;
    total++; if (stack_ptr !== 3'd0) $display("FAIL reset_ptr got %0d want 0", stack_ptr); else pass++;
    total++; if ({instr_flush, int_ack, gie_clr, gie_set} !== 4'b0) $display("FAIL reset_pulses got %b want 0000", {instr_flush, int_ack, gie_clr, gie_set}); else pass++;
    total++; if ({stack_ovf, stack_unf} !== 2'b0) $display("FAIL reset_flags got %b want 00", {stack_ovf, stack_unf}); else pass++;
    rst = 1;
  endtask

  task automatic test_incr();
    pc_incr_en = 1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      total++; if (pc_out !== 13'(i)) $display("FAIL incr_%0d got %h want %h", i, pc_out, 13'(i)); else pass++;
    end
    pc_incr_en = 0;
    set_pc(13'h1FFF);
    total++; if (pc_out !== 13'h1FFF) $display("FAIL pcl_max got %h want 1fff", pc_out); else pass++;
    pc_incr_en = 1;
    tick();
    pc_incr_en = 0;
    total++; if (pc_out !== 13'h0000) $display("FAIL incr_wrap got %h want 0000", pc_out); else pass++;
  endtask

  task automatic test_paging();
    pclath_wr_en = 1; pclath_in = 5'h18;
    tick();
    pclath_wr_en = 0; pc_j_en = 1; pc_j_addr = 11'h123;
    tick();
    pc_j_en = 0;
    total++; if (pc_out !== 13'h1923) $display("FAIL goto_page got %h want 1923", pc_out); else pass++;
    pcl_wr_en = 1; pcl_in = 8'h55; pclath_wr_en = 1; pclath_in = 5'h02; pc_incr_en = 1;
    tick();
    pcl_wr_en = 0; pclath_wr_en = 0; pc_incr_en = 0;
    total++; if (pc_out !== 13'h1855) $display("FAIL pcl_old_pclath got %h want 1855", pc_out); else pass++;
    total++; if (pclath_out !== 5'h02) $display("FAIL pclath_wr got %h want 02", pclath_out); else pass++;
  endtask

  task automatic test_call_return();
    set_pc(13'h0100);
    call_en = 1; pc_j_addr = 11'h200;
    tick();
    call_en = 0;
    total++; if (pc_out !== 13'h0200) $display("FAIL call_pc got %h want 0200", pc_out); else pass++;
    total++; if (stack_ptr !== 3'd1) $display("FAIL call_ptr got %0d want 1", stack_ptr); else pass++;
    return_en = 1; call_en = 1;
    tick();
    return_en = 0; call_en = 0;
    total++; if (pc_out !== 13'h0100) $display("FAIL return_pc got %h want 0100", pc_out); else pass++;
    total++; if (stack_ptr !== 3'd0) $display("FAIL return_ptr got %0d want 0", stack_ptr); else pass++;
  endtask

  task automatic test_stack_wrap();
    for (int i = 0; i < 9; i++) begin
      set_pc(13'(16 + i));
      call_en = 1; pc_j_addr = 11'h300;
      tick();
      call_en = 0;
    end
    total++; if (stack_ptr !== 3'd1) $display("FAIL ovf_ptr got %0d want 1", stack_ptr); else pass++;
    total++; if (stack_ovf !== STAT) $display("FAIL ovf_flag got %b want %b", stack_ovf, STAT); else pass++;
    total++; if (stack_unf !== 1'b0) $display("FAIL unf_early got %b want 0", stack_unf); else pass++;
    for (int i = 0; i < 8; i++) begin
      return_en = 1;
      tick();
      return_en = 0;
      total++; if (pc_out !== 13'(24 - i)) $display("FAIL pop_%0d got %h want %h", i, pc_out, 13'(24 - i)); else pass++;
    end
    total++; if (stack_unf !== 1'b0) $display("FAIL unf_before got %b want 0", stack_unf); else pass++;
    return_en = 1;
    tick();
    return_en = 0;
    total++; if (stack_unf !== STAT) $display("FAIL unf_flag got %b want %b", stack_unf, STAT); else pass++;
    total++; if (pc_out !== 13'h0018) $display("FAIL unf_pc got %h want 0018", pc_out); else pass++;
    total++; if (stack_ptr !== 3'd0) $display("FAIL unf_ptr got %0d want 0", stack_ptr); else pass++;
    total++; if (stack_ovf !== STAT) $display("FAIL ovf_sticky got %b want %b", stack_ovf, STAT); else pass++;
  endtask

  task automatic test_interrupt();
    set_pc(13'h0042);
    gie = 1; int_req = 1; boundary_en = 1; pc_j_en = 1; pc_j_addr = 11'h7FF;
    tick();
    gie = 0; int_req = 0; boundary_en = 0; pc_j_en = 0;
    total++; if (pc_out !== 13'h0004) $display("FAIL int_pc got %h want 0004", pc_out); else pass++;
    total++; if ({int_ack, gie_clr, instr_flush} !== 3'b111) $display("FAIL int_pulses got %b want 111", {int_ack, gie_clr, instr_flush}); else pass++;
    total++; if (stack_ptr !== 3'd1) $display("FAIL int_ptr got %0d want 1", stack_ptr); else pass++;
    pc_incr_en = 1; pclath_wr_en = 1; pclath_in = 5'h0A;
    tick();
    pc_incr_en = 0; pclath_wr_en = 0;
    total++; if (pc_out !== 13'h0004) $display("FAIL flush_ignore got %h want 0004", pc_out); else pass++;
    total++; if (pclath_out !== 5'h0A) $display("FAIL flush_pclath got %h want 0a", pclath_out); else pass++;
    total++; if ({int_ack, gie_clr, instr_flush} !== 3'b000) $display("FAIL int_end got %b want 000", {int_ack, gie_clr, instr_flush}); else pass++;
    retfie_en = 1;
    tick();
    retfie_en = 0;
    total++; if (pc_out !== 13'h0042) $display("FAIL retfie_pc got %h want 0042", pc_out); else pass++;
    total++; if (gie_set !== 1'b1) $display("FAIL gie_set got %b want 1", gie_set); else pass++;
    tick();
    total++; if (gie_set !== 1'b0) $display("FAIL gie_set_end got %b want 0", gie_set); else pass++;
  endtask

  task automatic test_int_gating();
    int_req = 1; gie = 0; boundary_en = 1; pc_incr_en = 1;
    tick();
    total++; if ({pc_out, int_ack} !== {13'h0043, 1'b0}) $display("FAIL no_gie got %h/%b want 0043/0", pc_out, int_ack); else pass++;
    gie = 1; boundary_en = 0;
    tick();
    total++; if ({pc_out, int_ack} !== {13'h0044, 1'b0}) $display("FAIL no_boundary got %h/%b want 0044/0", pc_out, int_ack); else pass++;
    boundary_en = 1;
    tick();
    int_req = 0; gie = 0; boundary_en = 0; pc_incr_en = 0;
    total++; if ({pc_out, instr_flush} !== {13'h0004, 1'b1}) $display("FAIL int_again got %h/%b want 0004/1", pc_out, instr_flush); else pass++;
    rst = 0;
    #1;
    total++; if ({pc_out, instr_flush, int_ack, gie_clr} !== {13'h0000, 3'b000}) $display("FAIL async_rst got %h/%b want 0000/000", pc_out, {instr_flush, int_ack, gie_clr}); else pass++;
    total++; if (stack_ptr !== 3'd0) $display("FAIL async_rst_ptr got %0d want 0", stack_ptr); else pass++;
    tick();
    rst = 1;
    tick();
    total++; if ({pc_out, instr_flush} !== {13'h0000, 1'b0}) $display("FAIL post_rst got %h/%b want 0000/0", pc_out, instr_flush); else pass++;
  endtask

  initial begin
    test_reset();
    test_incr();
    test_paging();
    test_call_return();
    test_stack_wrap();
    test_interrupt();
    test_int_gating();
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
